// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_if
// Brief    : Request/result bundle for the sequential binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, bcd, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, blank
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Double-dabble binary-to-BCD converter, one bit per clock, with a
//            leading-zero blank mask for the seven-segment display path.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    bin2bcd_seq_if.slave     bus
);

    localparam int c_cnt_w = $clog2(BIN_W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BIN_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [DIGITS-1:0]  c_blank_rst = ~(DIGITS'(1));

    function automatic bit cfg_ok();
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < DIGITS; i++) begin
            p = p * 128'd10;
        end
        return p > ((128'd1 << BIN_W) - 128'd1);
    endfunction

    if (!cfg_ok()) begin : g_cfg_check
        $error("bin2bcd_seq: 10**DIGITS must exceed 2**BIN_W - 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                     r_state;
    logic [BIN_W-1:0]           r_bin_sr;
    logic [4*DIGITS-1:0]        r_scratch;
    logic [c_cnt_w-1:0]         r_cnt;
    logic                       r_done;
    logic [4*DIGITS-1:0]        r_bcd;
    logic [DIGITS-1:0]          r_blank;

    logic [4*DIGITS-1:0]        w_adj;
    logic [4*DIGITS+BIN_W-1:0]  w_shift;
    logic [DIGITS-1:0]          w_blank;
    logic                       w_hi_zero;

    // Each nibble is corrected independently; carries never cross digits.
    genvar gi;
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                                ? r_scratch[4*gi +: 4] + 4'd3
                                : r_scratch[4*gi +: 4];
    end

    assign w_shift = {w_adj, r_bin_sr} << 1;

    // Walk down from the top digit; the ones digit is never blanked.
    always_comb begin
        w_blank   = '0;
        w_hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_hi_zero  = w_hi_zero && (r_scratch[4*i +: 4] == 4'd0);
            w_blank[i] = w_hi_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bin_sr  <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_blank   <= c_blank_rst;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bin_sr  <= bus.bin;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_shift[4*DIGITS+BIN_W-1:BIN_W];
                    r_bin_sr  <= w_shift[BIN_W-1:0];
                    r_cnt     <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_bcd   <= r_scratch;
                    r_blank <= w_blank;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = r_done;
    assign bus.bcd   = r_bcd;
    assign bus.blank = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Directed self-checking bench for bin2bcd_seq (16/5 and 8/3 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if16 ();
    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if8 ();

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input int val, input logic st);
        if (sel == 0) begin
            if16.bin   = 16'(val);
            if16.start = st;
        end else begin
            if8.bin   = 8'(val);
            if8.start = st;
        end
    endtask

    task automatic set_start(input int sel, input logic st);
        if (sel == 0) if16.start = st;
        else          if8.start  = st;
    endtask

    // Sample k is the falling edge after the k-th rising edge following acceptance.
    task automatic run_conv(input int sel, input int val, input int poke_at, input int poke_val,
                            output int lat, output int nbusy, output int ndone);
        logic b, d;
        @(negedge clk);
        set_in(sel, val, 1'b1);
        lat = 0; nbusy = 0; ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == poke_at) set_in(sel, poke_val, 1'b1);
            else              set_start(sel, 1'b0);
            b = (sel == 0) ? if16.busy : if8.busy;
            d = (sel == 0) ? if16.done : if8.done;
            if (b) nbusy++;
            if (d) begin
                ndone++;
                if (lat == 0) lat = k;
            end
        end
    endtask

    int          lat, nbusy, ndone, nd;
    int          dk [3];
    logic [19:0] rb [3];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_in(0, 0, 1'b0);
        set_in(1, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_busy",   64'(if16.busy),  64'd0);
        chk("rst_done",   64'(if16.done),  64'd0);
        chk("rst_bcd",    64'(if16.bcd),   64'h0);
        chk("rst_blank",  64'(if16.blank), 64'b11110);
        chk("rst_blank8", 64'(if8.blank),  64'b110);

        // zero input: latency, busy length, blank shows a single "0"
        run_conv(0, 0, 0, 0, lat, nbusy, ndone);
        chk("zero_lat",   64'(lat),        64'd18);
        chk("zero_busy",  64'(nbusy),      64'd17);
        chk("zero_ndone", 64'(ndone),      64'd1);
        chk("zero_bcd",   64'(if16.bcd),   64'h00000);
        chk("zero_blank", 64'(if16.blank), 64'b11110);

        run_conv(0, 65535, 0, 0, lat, nbusy, ndone);
        chk("max_bcd",    64'(if16.bcd),   64'h65535);
        chk("max_blank",  64'(if16.blank), 64'b00000);
        chk("max_ndone",  64'(ndone),      64'd1);

        // start with a new bin while busy must be ignored
        run_conv(0, 1234, 5, 9999, lat, nbusy, ndone);
        chk("ign_bcd",    64'(if16.bcd),   64'h01234);
        chk("ign_blank",  64'(if16.blank), 64'b10000);
        chk("ign_ndone",  64'(ndone),      64'd1);

        // start held high: back-to-back conversions, bin stepped at each done
        @(negedge clk);
        set_in(0, 7, 1'b1);
        nd = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (if16.done) begin
                if (nd < 3) begin
                    dk[nd] = k;
                    rb[nd] = if16.bcd;
                end
                nd++;
                if (nd == 1)      if16.bin = 16'd42;
                else if (nd == 2) if16.bin = 16'd100;
                else              if16.start = 1'b0;
            end
        end
        chk("b2b_ndone", 64'(nd),    64'd3);
        chk("b2b_t0",    64'(dk[0]), 64'd18);
        chk("b2b_t1",    64'(dk[1]), 64'd36);
        chk("b2b_t2",    64'(dk[2]), 64'd54);
        chk("b2b_bcd0",  64'(rb[0]), 64'h00007);
        chk("b2b_bcd1",  64'(rb[1]), 64'h00042);
        chk("b2b_bcd2",  64'(rb[2]), 64'h00100);
        set_start(0, 1'b0);

        // asynchronous reset in the middle of a conversion
        @(negedge clk);
        set_in(0, 500, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            set_start(0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  64'(if16.busy),  64'd0);
        chk("arst_bcd",   64'(if16.bcd),   64'h0);
        chk("arst_blank", 64'(if16.blank), 64'b11110);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (if16.done) ndone++;
        end
        chk("arst_nodone", 64'(ndone), 64'd0);

        run_conv(0, 500, 0, 0, lat, nbusy, ndone);
        chk("redo_bcd",   64'(if16.bcd),   64'h00500);
        chk("redo_blank", 64'(if16.blank), 64'b11000);
        chk("redo_ndone", 64'(ndone),      64'd1);

        // narrow build: 8-bit input, 3 digits
        run_conv(1, 255, 0, 0, lat, nbusy, ndone);
        chk("n8_lat",    64'(lat),       64'd10);
        chk("n8_busy",   64'(nbusy),     64'd9);
        chk("n8_bcd",    64'(if8.bcd),   64'h255);
        chk("n8_blank",  64'(if8.blank), 64'b000);

        run_conv(1, 9, 0, 0, lat, nbusy, ndone);
        chk("n8_bcd9",   64'(if8.bcd),   64'h009);
        chk("n8_blank9", 64'(if8.blank), 64'b110);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the per-digit seven-segment decoders on the DE2-115 display path. It accepts an unsigned binary value on a start pulse and produces packed BCD nibbles, one 4-bit nibble per display digit. It also produces a leading-zero blank mask, so display glue can suppress leading zeros.

Parameters:
BIN_W, 16, width of the unsigned binary input.
DIGITS, 5, number of BCD output digits. 10^DIGITS must exceed 2^BIN_W - 1; an elaboration-time check fails otherwise.

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  asynchronous active-low reset.
start  input  1  conversion request; sampled only in IDLE.
bin  input  BIN_W  unsigned value; captured on the edge that accepts start.
busy  output  1  high while a conversion is in progress (state != IDLE).
done  output  1  one-cycle pulse; bcd and blank were updated on the same edge.
bcd  output  4*DIGITS  packed result; digit 0 (ones) is bits [3:0], digit i is bits [4i+3:4i]; each nibble is 0..9.
blank  output  DIGITS  bit i=1 when digit i and all higher digits are zero; bit 0 is always 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Reset values:
  - state = IDLE, busy = 0, done = 0.
  - bcd = 0.
  - blank = all ones except bit 0 (a zero display shows a single "0").
  - Internal shift register and counter = 0.
- Internal registers:
  - bin_sr: BIN_W bits.
  - scratch: 4*DIGITS bits.
  - cnt: clog2(BIN_W+1) bits.
- State IDLE:
  - If start=1 at edge E0: bin_sr <= bin, scratch <= 0, cnt <= 0, next state SHIFT.
  - If start=0: remain in IDLE; outputs hold.
- State SHIFT, on each edge:
  1. For every nibble of scratch with value >= 5, add 3 to that nibble (no carry between nibbles).
  2. Shift {adjusted scratch, bin_sr} left by 1 bit; the MSB of bin_sr enters scratch bit 0.
  3. cnt increments.
  - On the BIN_W-th shift edge (E_BIN_W), move to FINISH.
- State FINISH: at edge E(BIN_W+1): bcd <= scratch, blank <= mask computed from scratch, done <= 1, next state IDLE.
- done:
  - Registered; high exactly for the cycle after E(BIN_W+1).
  - Cleared at the next edge unconditionally.
- busy: combinational decode of the registered state; high in SHIFT and FINISH.
- Latency: BIN_W+1 edges from start acceptance to result update. The earliest next acceptance is the edge ending the done cycle, so minimum issue period is BIN_W+2 cycles.
- Start handling:
  - start while busy (SHIFT or FINISH) is ignored, not queued; bin changes during busy have no effect.
  - start held permanently high yields back-to-back conversions, each reading bin at its acceptance edge.
- Output holding: bcd and blank hold the previous result during a conversion; they change only on the FINISH edge.
- Reset mid-operation: the conversion is aborted, no done pulse is issued, and all registers return to reset values.
- Arithmetic: the add-3 is applied per nibble in 4 bits; the shift is a plain logical shift. With a legal DIGITS setting, the top nibble never overflows.

Test Plan:
- Reset, then bin=0 and start for 1 cycle -> done exactly 17 cycles after the start edge, bcd=0x00000, blank=5'b11110, busy high for 17 cycles.
- bin=65535 -> bcd=0x65535, blank=5'b00000, single-cycle done pulse.
- bin=1234, then bin changed to 9999 and start pulsed while busy -> bcd=0x01234, blank=5'b10000, only one done pulse, the second start is ignored.
- start held high with bin stepping 7, 42, 100 at each acceptance -> done every 18 cycles, bcd=0x00007, 0x00042, 0x00100 in order.
- rst_n asserted 5 cycles after accepting bin=500 -> busy=0 and bcd=0 immediately (asynchronously), no done pulse; a fresh start with bin=500 gives bcd=0x00500.
- BIN_W=8, DIGITS=3 with bin=255 -> bcd=0x255, done 9 cycles after start; bin=9 -> bcd=0x009, blank=3'b110.
